// File: rtl/wave_param_meas.sv
// Waveform parameter measurement: period, full-cycle count, span and peak/trough levels
// of an 8-bit sampled waveform, measured inside a gate window using hysteretic
// rising-crossing detection around mid-scale.
module wave_param_meas #(
  parameter int unsigned DW     = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NCYC_W = 16,
  parameter int unsigned MID    = 128,
  parameter int unsigned HYST   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gate,
  input  logic              valid,
  input  logic [DW-1:0]     wave_in,
  output logic              meas_done,
  output logic              meas_err,
  output logic              meas_ovf,
  output logic [CNT_W-1:0]  last_period,
  output logic [CNT_W-1:0]  span_cycles,
  output logic [NCYC_W-1:0] n_cycles,
  output logic [DW-1:0]     vmax,
  output logic [DW-1:0]     vmin,
  output logic [DW-1:0]     vpp
);

  localparam logic [DW-1:0] HiTh = DW'(MID + HYST);
  localparam logic [DW-1:0] LoTh = DW'(MID - HYST);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StDone} state_e;

  state_e state_q, state_d;

  logic [DW-1:0]     s_q;
  logic              v_q;
  logic              gate_q, gate_prev_q;
  logic              pend_q;
  logic              armed_q;
  logic [DW-1:0]     max_q, min_q;
  logic              seen_q;
  logic [CNT_W-1:0]  span_q, prev_q, per_q;
  logic [NCYC_W-1:0] ncyc_q;
  logic              ovf_q;

  logic              gate_rise;
  logic              rise_x;
  logic              low_x;
  logic              err_now;
  logic [CNT_W-1:0]  span_inc;
  logic [NCYC_W-1:0] ncyc_inc;

  // Crossing detection, saturating increments and error condition
  always_comb begin
    gate_rise = gate_q & ~gate_prev_q;
    rise_x    = v_q & armed_q & (s_q >= HiTh);
    low_x     = v_q & (s_q <= LoTh);
    span_inc  = (&span_q) ? span_q : span_q + 1'b1;
    ncyc_inc  = (&ncyc_q) ? ncyc_q : ncyc_q + 1'b1;
    // Fewer than two crossings: never left ARM, or no full period counted yet
    err_now   = (state_q == StArm) || (ncyc_q == '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (gate_rise || pend_q) state_d = StArm;
      StArm: begin
        if (!gate_q)     state_d = StDone;
        else if (rise_x) state_d = StMeasure;
      end
      StMeasure: if (!gate_q) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign meas_done = (state_q == StDone);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Input stage, gate edge latch, trackers, counters and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= '0;
      v_q         <= 1'b0;
      // Gate history resets high so a gate held high through reset is not an edge
      gate_q      <= 1'b1;
      gate_prev_q <= 1'b1;
      pend_q      <= 1'b0;
      armed_q     <= 1'b0;
      max_q       <= '0;
      min_q       <= '1;
      seen_q      <= 1'b0;
      span_q      <= '0;
      prev_q      <= '0;
      per_q       <= '0;
      ncyc_q      <= '0;
      ovf_q       <= 1'b0;
      meas_err    <= 1'b0;
      meas_ovf    <= 1'b0;
      last_period <= '0;
      span_cycles <= '0;
      n_cycles    <= '0;
      vmax        <= '0;
      vmin        <= '0;
      vpp         <= '0;
    end else begin
      s_q         <= wave_in;
      v_q         <= valid;
      gate_q      <= gate;
      gate_prev_q <= gate_q;

      // An edge seen outside IDLE (e.g. during DONE) is held until IDLE takes it
      if (state_q == StIdle) pend_q <= 1'b0;
      else if (gate_rise)    pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (gate_rise || pend_q) begin
            armed_q <= 1'b0;
            max_q   <= '0;
            min_q   <= '1;
            seen_q  <= 1'b0;
            span_q  <= '0;
            prev_q  <= '0;
            per_q   <= '0;
            ncyc_q  <= '0;
            ovf_q   <= 1'b0;
          end
        end
        StArm, StMeasure: begin
          if (gate_q) begin
            if (v_q) begin
              seen_q <= 1'b1;
              if (s_q > max_q) max_q <= s_q;
              if (s_q < min_q) min_q <= s_q;
            end
            if (rise_x)     armed_q <= 1'b0;
            else if (low_x) armed_q <= 1'b1;

            if (state_q == StArm) begin
              if (rise_x) begin
                span_q <= '0;
                prev_q <= '0;
              end
            end else begin
              span_q <= span_inc;
              if (&span_q) ovf_q <= 1'b1;
              if (rise_x) begin
                per_q  <= span_inc - prev_q;
                prev_q <= span_inc;
                ncyc_q <= ncyc_inc;
              end
            end
          end else begin
            // Window closing: publish results, visible in the DONE cycle
            meas_err    <= err_now;
            meas_ovf    <= ovf_q;
            last_period <= err_now ? '0 : per_q;
            span_cycles <= err_now ? '0 : prev_q;
            n_cycles    <= err_now ? '0 : ncyc_q;
            vmax        <= seen_q ? max_q : '0;
            vmin        <= seen_q ? min_q : '0;
            vpp         <= seen_q ? (max_q - min_q) : '0;
          end
        end
        StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_param_meas.sv
// Directed bench for wave_param_meas: square, triangle, constant, gappy-valid, noisy,
// mid-window reset and back-to-back windows with hand-computed expectations.
module tb_wave_param_meas;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gate = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  wave_in = 8'd0;
  logic        meas_done, meas_err, meas_ovf;
  logic [31:0] last_period, span_cycles;
  logic [15:0] n_cycles;
  logic [7:0]  vmax, vmin, vpp;

  wave_param_meas dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gate       (gate),
    .valid      (valid),
    .wave_in    (wave_in),
    .meas_done  (meas_done),
    .meas_err   (meas_err),
    .meas_ovf   (meas_ovf),
    .last_period(last_period),
    .span_cycles(span_cycles),
    .n_cycles   (n_cycles),
    .vmax       (vmax),
    .vmin       (vmin),
    .vpp        (vpp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] sp_per [16];
  logic [31:0] sp_span[16];
  logic [15:0] sp_n   [16];
  logic [7:0]  sp_max [16];
  logic [7:0]  sp_min [16];
  logic [7:0]  sp_pp  [16];
  logic        sp_err [16];
  logic        sp_ovf [16];
  int          sp_cyc [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot outputs on every done pulse
  always @(negedge clk) begin
    if (meas_done) begin
      if (done_cnt < 16) begin
        sp_per[done_cnt]  <= last_period;
        sp_span[done_cnt] <= span_cycles;
        sp_n[done_cnt]    <= n_cycles;
        sp_max[done_cnt]  <= vmax;
        sp_min[done_cnt]  <= vmin;
        sp_pp[done_cnt]   <= vpp;
        sp_err[done_cnt]  <= meas_err;
        sp_ovf[done_cnt]  <= meas_ovf;
        sp_cyc[done_cnt]  <= cyc;
      end
      done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind 0 square 31/225 P100; 1 triangle 97..159 P64; 2 constant 128;
  // 3 square with valid on odd samples (invalid samples carry 0/255); 4 square with mid noise
  function automatic logic [8:0] gen(input int kind, input int idx);
    int ph;
    logic [7:0] v;
    logic vl;
    logic [31:0] ib;
    ib = idx;
    ph = idx % 100;
    vl = 1'b1;
    v  = 8'd0;
    case (kind)
      0: v = (ph < 50) ? 8'd31 : 8'd225;
      1: begin
        ph = idx % 64;
        v  = (ph < 32) ? 8'(97 + 2 * ph) : 8'(159 - 2 * (ph - 32));
      end
      2: v = 8'd128;
      3: begin
        vl = ib[0];
        v  = vl ? ((ph < 50) ? 8'd31 : 8'd225) : (ib[1] ? 8'd0 : 8'd255);
      end
      4: begin
        if (ph < 40)      v = 8'd31;
        else if (ph < 50) v = ib[0] ? 8'd131 : 8'd125;
        else if (ph < 90) v = 8'd225;
        else              v = ib[0] ? 8'd131 : 8'd125;
      end
      default: v = 8'd0;
    endcase
    return {vl, v};
  endfunction

  task automatic drive(input int kind, input int idx, input logic g);
    @(posedge clk);
    #1;
    gate = g;
    {valid, wave_in} = gen(kind, idx);
  endtask

  // One gated window of len samples; returns snapshot slot (-1 on timeout) and done latency
  task automatic run_window(input int kind, input int len, output int slot, output int lat);
    int start;
    int fall;
    start = done_cnt;
    slot  = -1;
    lat   = -1;
    for (int i = 0; i < len; i++) drive(kind, i, 1'b1);
    drive(kind, len, 1'b0);
    fall = cyc;
    for (int k = 0; k < 20; k++) begin
      drive(kind, len + 1 + k, 1'b0);
      if (done_cnt > start) begin
        slot = start;
        lat  = sp_cyc[start] - fall;
        break;
      end
    end
    if (slot < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout kind %0d: no meas_done within 20 clk", kind);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (meas_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", meas_done); end
    n_cmp++; if (meas_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", meas_err); end
    n_cmp++; if (meas_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", meas_ovf); end
    n_cmp++; if (last_period !== 32'd0) begin n_bad++; $display("FAIL rst_period got %0d want 0", last_period); end
    n_cmp++; if (span_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_span got %0d want 0", span_cycles); end
    n_cmp++; if (n_cycles !== 16'd0) begin n_bad++; $display("FAIL rst_ncyc got %0d want 0", n_cycles); end
    n_cmp++; if ({vmax, vmin, vpp} !== 24'd0) begin n_bad++; $display("FAIL rst_levels got %0d/%0d/%0d want 0/0/0", vmax, vmin, vpp); end
  endtask

  // Square 31/225, period 100, 1000-clk gate: crossings at samples 50..950
  task automatic test_square();
    int s, lat;
    run_window(0, 1000, s, lat);
    if (s < 0) return;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sq_latency got %0d want 2", lat); end
    n_cmp++; if (sp_per[s] !== 32'd100) begin n_bad++; $display("FAIL sq_period got %0d want 100", sp_per[s]); end
    n_cmp++; if (sp_n[s] !== 16'd9) begin n_bad++; $display("FAIL sq_ncyc got %0d want 9", sp_n[s]); end
    n_cmp++; if (sp_span[s] !== 32'd900) begin n_bad++; $display("FAIL sq_span got %0d want 900", sp_span[s]); end
    n_cmp++; if (sp_max[s] !== 8'd225) begin n_bad++; $display("FAIL sq_vmax got %0d want 225", sp_max[s]); end
    n_cmp++; if (sp_min[s] !== 8'd31) begin n_bad++; $display("FAIL sq_vmin got %0d want 31", sp_min[s]); end
    n_cmp++; if (sp_pp[s] !== 8'd194) begin n_bad++; $display("FAIL sq_vpp got %0d want 194", sp_pp[s]); end
    n_cmp++; if ({sp_err[s], sp_ovf[s]} !== 2'b00) begin n_bad++; $display("FAIL sq_flags got err=%b ovf=%b want 0/0", sp_err[s], sp_ovf[s]); end
  endtask

  // Triangle, period 64, crossings at 18+64m, last at 9938 -> 155 full periods
  task automatic test_triangle();
    int s, lat;
    run_window(1, 10000, s, lat);
    if (s < 0) return;
    n_cmp++; if (sp_per[s] !== 32'd64) begin n_bad++; $display("FAIL tri_period got %0d want 64", sp_per[s]); end
    n_cmp++; if (sp_n[s] !== 16'd155) begin n_bad++; $display("FAIL tri_ncyc got %0d want 155", sp_n[s]); end
    n_cmp++; if (sp_span[s] !== 32'd9920) begin n_bad++; $display("FAIL tri_span got %0d want 9920", sp_span[s]); end
    n_cmp++; if (sp_max[s] !== 8'd159) begin n_bad++; $display("FAIL tri_vmax got %0d want 159", sp_max[s]); end
    n_cmp++; if (sp_min[s] !== 8'd97) begin n_bad++; $display("FAIL tri_vmin got %0d want 97", sp_min[s]); end
    n_cmp++; if (sp_pp[s] !== 8'd62) begin n_bad++; $display("FAIL tri_vpp got %0d want 62", sp_pp[s]); end
    n_cmp++; if (sp_err[s] !== 1'b0) begin n_bad++; $display("FAIL tri_err got %b want 0", sp_err[s]); end
  endtask

  task automatic test_constant();
    int s, lat;
    run_window(2, 500, s, lat);
    if (s < 0) return;
    n_cmp++; if (sp_err[s] !== 1'b1) begin n_bad++; $display("FAIL const_err got %b want 1", sp_err[s]); end
    n_cmp++; if (sp_per[s] !== 32'd0) begin n_bad++; $display("FAIL const_period got %0d want 0", sp_per[s]); end
    n_cmp++; if (sp_span[s] !== 32'd0) begin n_bad++; $display("FAIL const_span got %0d want 0", sp_span[s]); end
    n_cmp++; if (sp_n[s] !== 16'd0) begin n_bad++; $display("FAIL const_ncyc got %0d want 0", sp_n[s]); end
    n_cmp++; if ({sp_max[s], sp_min[s], sp_pp[s]} !== {8'd128, 8'd128, 8'd0}) begin
      n_bad++; $display("FAIL const_levels got %0d/%0d/%0d want 128/128/0", sp_max[s], sp_min[s], sp_pp[s]);
    end
  endtask

  // Valid only on odd samples: crossing moves to 51, period unchanged
  task automatic test_valid_gaps();
    int s, lat;
    run_window(3, 1000, s, lat);
    if (s < 0) return;
    n_cmp++; if (sp_per[s] !== 32'd100) begin n_bad++; $display("FAIL gap_period got %0d want 100", sp_per[s]); end
    n_cmp++; if (sp_n[s] !== 16'd9) begin n_bad++; $display("FAIL gap_ncyc got %0d want 9", sp_n[s]); end
    n_cmp++; if (sp_max[s] !== 8'd225) begin n_bad++; $display("FAIL gap_vmax got %0d want 225", sp_max[s]); end
    n_cmp++; if (sp_min[s] !== 8'd31) begin n_bad++; $display("FAIL gap_vmin got %0d want 31", sp_min[s]); end
  endtask

  task automatic test_noise();
    int s, lat;
    run_window(4, 1000, s, lat);
    if (s < 0) return;
    n_cmp++; if (sp_per[s] !== 32'd100) begin n_bad++; $display("FAIL noise_period got %0d want 100", sp_per[s]); end
    n_cmp++; if (sp_n[s] !== 16'd9) begin n_bad++; $display("FAIL noise_ncyc got %0d want 9", sp_n[s]); end
    n_cmp++; if (sp_span[s] !== 32'd900) begin n_bad++; $display("FAIL noise_span got %0d want 900", sp_span[s]); end
  endtask

  task automatic test_reset_mid();
    int start;
    for (int i = 0; i < 300; i++) drive(0, i, 1'b1);
    start = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b0;
    {valid, wave_in} = gen(0, 300);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({meas_err, meas_ovf} !== 2'b00) begin n_bad++; $display("FAIL midrst_flags got %b%b want 00", meas_err, meas_ovf); end
    n_cmp++; if ({last_period, span_cycles} !== 64'd0) begin n_bad++; $display("FAIL midrst_counts got %0d/%0d want 0/0", last_period, span_cycles); end
    n_cmp++; if ({n_cycles, vmax, vmin, vpp} !== 40'd0) begin
      n_bad++; $display("FAIL midrst_levels got n=%0d %0d/%0d/%0d want 0", n_cycles, vmax, vmin, vpp);
    end
    for (int i = 302; i < 500; i++) drive(0, i, 1'b1);
    for (int i = 0; i < 20; i++) drive(0, 500 + i, 1'b0);
    n_cmp++; if (done_cnt !== start) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", done_cnt - start); end
  endtask

  // Two 500-clk windows separated by one low gate clk
  task automatic test_back_to_back();
    int start;
    start = done_cnt;
    for (int i = 0; i < 500; i++) drive(0, i, 1'b1);
    drive(0, 500, 1'b0);
    for (int i = 0; i < 500; i++) drive(4, i, 1'b1);
    drive(4, 500, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (done_cnt >= start + 2) break;
      drive(4, 501 + k, 1'b0);
    end
    n_cmp++; if (done_cnt - start !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", done_cnt - start); end
    if (done_cnt - start < 2) return;
    n_cmp++; if (sp_per[start] !== 32'd100 || sp_n[start] !== 16'd4 || sp_span[start] !== 32'd400) begin
      n_bad++; $display("FAIL b2b_w1 got per=%0d n=%0d span=%0d want 100/4/400", sp_per[start], sp_n[start], sp_span[start]);
    end
    n_cmp++; if (sp_per[start+1] !== 32'd100 || sp_n[start+1] !== 16'd4 || sp_span[start+1] !== 32'd400) begin
      n_bad++; $display("FAIL b2b_w2 got per=%0d n=%0d span=%0d want 100/4/400", sp_per[start+1], sp_n[start+1], sp_span[start+1]);
    end
    n_cmp++; if (sp_err[start+1] !== 1'b0 || sp_pp[start+1] !== 8'd194) begin
      n_bad++; $display("FAIL b2b_w2_levels got err=%b vpp=%0d want 0/194", sp_err[start+1], sp_pp[start+1]);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_triangle();
    test_constant();
    test_valid_gaps();
    test_noise();
    test_reset_mid();
    test_square();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
